// File: rtl/robo_pkg.sv
// Shared definitions for the wall follower controller.
//   state_e      : FSM state encodings (SEARCH, FOLLOW, ROT_AWAY, TURN_IN, ADVANCE)
//   DIR_LEFT/RIGHT: Rotate_Dir values (0 = CCW, 1 = CW)
//   sat_inc      : saturating increment helper for small counters
package robo_pkg;

    typedef enum logic [2:0] {
        SEARCH   = 3'd0,
        FOLLOW   = 3'd1,
        ROT_AWAY = 3'd2,
        TURN_IN  = 3'd3,
        ADVANCE  = 3'd4
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Increment a 32-bit view of a counter, holding at lim once reached.
    function automatic int unsigned sat_inc(input int unsigned val, input int unsigned lim);
        return (val >= lim) ? lim : val + 1;
    endfunction

endpackage

// File: rtl/wall_follower_ctrl_if.sv
// Signal bundle between the sensor/motor side and the controller.
//   Head, Side, Wall_Side          : raw sensor inputs and follow-side select
//   Front, Rotate, Rotate_Dir      : motor commands
//   Tick, Stuck, State             : timing pulse, give-up pulse, debug state
// All signals are plain levels; there is no handshake. The master drives the
// sensors and observes the motor/debug outputs; the slave is the controller.
interface wall_follower_ctrl_if;
    logic       Head;
    logic       Side;
    logic       Wall_Side;
    logic       Front;
    logic       Rotate;
    logic       Rotate_Dir;
    logic       Tick;
    logic       Stuck;
    logic [2:0] State;

    modport master (
        output Head, Side, Wall_Side,
        input  Front, Rotate, Rotate_Dir, Tick, Stuck, State
    );

    modport slave (
        input  Head, Side, Wall_Side,
        output Front, Rotate, Rotate_Dir, Tick, Stuck, State
    );
endinterface

// File: rtl/sensor_debounce.sv
// Tick-sampled debouncer for one raw sensor bit.
//   initial_Clock : system clock
//   Reset_n       : asynchronous active-low reset
//   Tick          : sample enable
//   raw           : raw sensor level
//   clean         : accepted level, updated once raw has been identical for
//                   DEBOUNCE consecutive tick samples (current one included)
module sensor_debounce #(
    parameter int DEBOUNCE = 2
) (
    input  logic initial_Clock,
    input  logic Reset_n,
    input  logic Tick,
    input  logic raw,
    output logic clean
);
    localparam int RW = $clog2(DEBOUNCE) + 1;
    localparam logic [RW-1:0] RUN_LIM = RW'(DEBOUNCE);

    logic          last;
    logic [RW-1:0] run;
    logic [RW-1:0] run_next;

    // run counts how many consecutive samples (ending now) share raw's value.
    always_comb begin
        run_next = RW'(1);
        if (raw == last) begin
            run_next = (run >= RUN_LIM) ? run : run + RW'(1);
        end
    end

    always_ff @(posedge initial_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            last  <= 1'b0;
            run   <= '0;
            clean <= 1'b0;
        end else if (Tick) begin
            last <= raw;
            run  <= run_next;
            if (run_next >= RUN_LIM) begin
                clean <= raw;
            end
        end
    end
endmodule

// File: rtl/wall_follower_ctrl.sv
// Single-wall follower controller with tick divider, debounced sensors,
// selectable follow side, timed rotate/advance manoeuvres and stuck detection.
//   initial_Clock : system clock
//   Reset_n       : asynchronous active-low reset
//   bus (slave)   : Head/Side/Wall_Side in; Front/Rotate/Rotate_Dir motor
//                   commands, Tick pulse, Stuck pulse and State debug out
module wall_follower_ctrl
    import robo_pkg::*;
#(
    parameter int CLOCK_DIVIDER = 6,
    parameter int DEBOUNCE      = 2,
    parameter int TURN_TICKS    = 3,
    parameter int ADV_TICKS     = 2,
    parameter int STUCK_LIMIT   = 4
) (
    input  logic                 initial_Clock,
    input  logic                 Reset_n,
    wall_follower_ctrl_if.slave  bus
);
    localparam logic [2:0] ST_SEARCH   = 3'(SEARCH);
    localparam logic [2:0] ST_FOLLOW   = 3'(FOLLOW);
    localparam logic [2:0] ST_ROT_AWAY = 3'(ROT_AWAY);
    localparam logic [2:0] ST_TURN_IN  = 3'(TURN_IN);
    localparam logic [2:0] ST_ADVANCE  = 3'(ADVANCE);

    localparam int DW   = $clog2(CLOCK_DIVIDER) + 1;
    localparam int TMAX = (TURN_TICKS > ADV_TICKS) ? TURN_TICKS : ADV_TICKS;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int LW   = $clog2(STUCK_LIMIT) + 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLOCK_DIVIDER - 1);
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_TICKS);
    localparam logic [TW-1:0] ADV_LOAD  = TW'(ADV_TICKS);
    localparam logic [LW-1:0] LOST_LIM  = LW'(STUCK_LIMIT);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          h;
    logic          s;
    logic [2:0]    state,  state_next;
    logic [TW-1:0] timer,  timer_next;
    logic [LW-1:0] lost,   lost_next;
    logic          side_l;
    logic          side_eff;
    logic          stuck_next;
    logic          front_next, rotate_next, dir_next;
    logic          front_q, rotate_q, dir_q, stuck_q;

    // ---------------- divider ----------------
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge initial_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // ---------------- debouncers ----------------
    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_head_db (
        .initial_Clock (initial_Clock),
        .Reset_n       (Reset_n),
        .Tick          (tick),
        .raw           (bus.Head),
        .clean         (h)
    );

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_side_db (
        .initial_Clock (initial_Clock),
        .Reset_n       (Reset_n),
        .Tick          (tick),
        .raw           (bus.Side),
        .clean         (s)
    );

    // ---------------- FSM next state ----------------
    // side_l is refreshed on this very tick while in SEARCH, so a manoeuvre
    // started from SEARCH must already use the new Wall_Side value.
    assign side_eff = (state == ST_SEARCH) ? bus.Wall_Side : side_l;

    always_comb begin
        state_next = state;
        timer_next = timer;
        lost_next  = lost;
        stuck_next = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (h) begin
                    state_next = ST_ROT_AWAY;
                    timer_next = TURN_LOAD;
                end else if (s) begin
                    state_next = ST_FOLLOW;
                end
            end
            ST_FOLLOW: begin
                lost_next = '0;
                if (h) begin
                    state_next = ST_ROT_AWAY;
                    timer_next = TURN_LOAD;
                end else if (!s) begin
                    state_next = ST_TURN_IN;
                    timer_next = TURN_LOAD;
                end
            end
            ST_ROT_AWAY: begin
                if (timer <= TW'(1)) begin
                    if (h) begin
                        timer_next = TURN_LOAD;
                    end else if (s) begin
                        state_next = ST_FOLLOW;
                        timer_next = '0;
                    end else begin
                        state_next = ST_SEARCH;
                        timer_next = '0;
                    end
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            ST_TURN_IN: begin
                if (timer <= TW'(1)) begin
                    lost_next  = LW'(sat_inc(32'(lost), 32'(STUCK_LIMIT)));
                    state_next = ST_ADVANCE;
                    timer_next = ADV_LOAD;
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            ST_ADVANCE: begin
                // A wall ahead cuts the advance short regardless of timer.
                if (h) begin
                    state_next = ST_ROT_AWAY;
                    timer_next = TURN_LOAD;
                end else if (timer <= TW'(1)) begin
                    if (s) begin
                        state_next = ST_FOLLOW;
                        timer_next = '0;
                    end else if (lost == LOST_LIM) begin
                        state_next = ST_SEARCH;
                        timer_next = '0;
                        lost_next  = '0;
                        stuck_next = 1'b1;
                    end else begin
                        state_next = ST_TURN_IN;
                        timer_next = TURN_LOAD;
                    end
                end else begin
                    timer_next = timer - TW'(1);
                end
            end
            default: begin
                state_next = ST_SEARCH;
                timer_next = '0;
            end
        endcase
    end

    // Moore outputs derived from the state being entered, registered with it.
    always_comb begin
        front_next  = 1'b0;
        rotate_next = 1'b0;
        dir_next    = DIR_LEFT;
        case (state_next)
            ST_SEARCH, ST_FOLLOW, ST_ADVANCE: front_next = 1'b1;
            ST_ROT_AWAY: begin
                rotate_next = 1'b1;
                dir_next    = ~side_eff;
            end
            ST_TURN_IN: begin
                rotate_next = 1'b1;
                dir_next    = side_eff;
            end
            default: front_next = 1'b0;
        endcase
    end

    always_ff @(posedge initial_Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_SEARCH;
            timer    <= '0;
            lost     <= '0;
            side_l   <= DIR_LEFT;
            front_q  <= 1'b0;
            rotate_q <= 1'b0;
            dir_q    <= 1'b0;
            stuck_q  <= 1'b0;
        end else if (tick) begin
            state    <= state_next;
            timer    <= timer_next;
            lost     <= lost_next;
            if (state == ST_SEARCH) begin
                side_l <= bus.Wall_Side;
            end
            front_q  <= front_next;
            rotate_q <= rotate_next;
            dir_q    <= dir_next;
            stuck_q  <= stuck_next;
        end
    end

    assign bus.Front      = front_q;
    assign bus.Rotate     = rotate_q;
    assign bus.Rotate_Dir = dir_q;
    assign bus.Stuck      = stuck_q;
    assign bus.Tick       = tick;
    assign bus.State      = state;
endmodule
